// File: rtl/fifo_burst_pkg.sv
// Shared types and defaults for the FIFO burst reader and its skid buffer.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } burst_state_e;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefBurstLen  = 4;
    localparam int unsigned DefBcntWidth = 3;
    localparam logic [15:0] DefPadValue  = 16'h0000;

    // True when one more word can be committed to the 2-entry buffer, counting the word
    // still in flight from the FIFO and any word leaving the buffer this cycle.
    function automatic logic has_space(logic [1:0] buf_count, logic inflight, logic pop);
        logic [2:0] occ;
        occ = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Valid/ready stream carrying burst words with an end-of-burst marker.
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_skid_buf2.sv
// Two-entry {last, data} buffer. Push and pop may coincide, including when full.
module fifo_skid_buf2 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } skid_entry_t;

    skid_entry_t mem_q [2];
    skid_entry_t mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_pop, push_ok, wr_ptr;

    // Next-state: write slot is head + count (mod 2); a full buffer accepts a push only
    // when the head leaves in the same cycle, in which case the head slot is reused.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop & (count_q != 2'd0);
        push_ok  = push & ((count_q != 2'd2) | do_pop);
        wr_ptr   = rd_ptr_q ^ count_q[0];
        if (push_ok) begin
            mem_d[wr_ptr] = '{last: push_last, data: push_data};
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, do_pop};
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head of queue.
    always_comb begin
        count     = count_q;
        head_last = mem_q[rd_ptr_q].last;
        head_data = mem_q[rd_ptr_q].data;
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads words from a FIFO with one-cycle read latency and re-emits them as fixed-length
// bursts on a valid/ready stream, padding short bursts when flush is held.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = DefDataWidth,
    parameter int unsigned         BURST_LEN  = DefBurstLen,
    parameter int unsigned         BCNT_WIDTH = DefBcntWidth,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = DATA_WIDTH'(DefPadValue)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   fifo_empty,
    input  logic                   fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data_out,
    output logic                   fifo_read_en,
    fifo_burst_reader_if.master    strm,
    output logic                   busy,
    output logic [15:0]            bursts_done,
    output logic                   rd_err
);
    localparam logic [BCNT_WIDTH-1:0] BurstLen = BCNT_WIDTH'(BURST_LEN);
    localparam logic [BCNT_WIDTH-1:0] LastIdx  = BCNT_WIDTH'(BURST_LEN - 1);

    burst_state_e          state_q, state_d;
    logic [BCNT_WIDTH-1:0] issued_q, issued_d;
    logic [BCNT_WIDTH-1:0] accepted_q, accepted_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic [15:0]           bursts_done_q, bursts_done_d;
    logic                  rd_err_q, rd_err_d;

    logic [1:0]            buf_count;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop, can_issue, pad_push, push, push_last;
    logic [DATA_WIDTH-1:0] push_data;

    fifo_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_last (push_last),
        .push_data (push_data),
        .pop       (pop),
        .count     (buf_count),
        .head_last (head_last),
        .head_data (head_data)
    );

    // Read issue, pad insertion, buffer push selection and FSM next state.
    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        accepted_d      = accepted_q;
        bursts_done_d   = bursts_done_q;
        pop             = strm.m_ready & (buf_count != 2'd0);
        can_issue       = (state_q == StBurst) & (issued_q < BurstLen) &
                          has_space(buf_count, inflight_q, pop);
        fifo_read_en    = can_issue & ~fifo_empty;
        // A pad waits for any outstanding read so words never overtake each other.
        pad_push        = can_issue & fifo_empty & flush & ~inflight_q;
        push            = inflight_q | pad_push;
        push_last       = inflight_q ? inflight_last_q : (issued_q == LastIdx);
        push_data       = inflight_q ? fifo_data_out : PAD_VALUE;
        inflight_d      = fifo_read_en;
        inflight_last_d = fifo_read_en & (issued_q == LastIdx);
        rd_err_d        = rd_err_q | (fifo_read_en & fifo_empty);
        if (pop) begin
            accepted_d = accepted_q + BCNT_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (enable && !fifo_empty && (!fifo_almost_empty || flush)) begin
                    state_d    = StBurst;
                    issued_d   = '0;
                    accepted_d = '0;
                end
            end
            StBurst: begin
                if (fifo_read_en || pad_push) begin
                    issued_d = issued_q + BCNT_WIDTH'(1);
                    if (issued_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && head_last) begin
                    state_d       = StIdle;
                    bursts_done_d = bursts_done_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            issued_q        <= '0;
            accepted_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            bursts_done_q   <= 16'd0;
            rd_err_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            accepted_q      <= accepted_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            bursts_done_q   <= bursts_done_d;
            rd_err_q        <= rd_err_d;
        end
    end

    // Stream and status outputs; data and last are forced low when nothing is buffered.
    always_comb begin
        strm.m_valid = (buf_count != 2'd0);
        strm.m_data  = strm.m_valid ? head_data : '0;
        strm.m_last  = strm.m_valid & head_last;
        busy         = (state_q != StIdle);
        bursts_done  = bursts_done_q;
        rd_err       = rd_err_q;
    end

endmodule
